// File: rtl/pixel_write_receiver.sv
// pixel_write_receiver
//   Turns rising edges of print_enable into framebuffer writes. Each edge
//   captures one (x, y, colour) request; out-of-screen requests are dropped,
//   in-screen requests are turned into a linear address and queued in a small
//   FIFO, then issued to the framebuffer with a valid/ready style handshake.
//
// Ports
//   Clck          in   clock, rising edge
//   Reset         in   asynchronous active-low reset
//   paint_x_co    in   requested pixel x            [XW]
//   paint_y_co    in   requested pixel y            [YW]
//   color         in   requested pixel colour       [3]
//   print_enable  in   request strobe (edge-detected)
//   mem_ready     in   framebuffer accepts a write this cycle
//   clear_flags   in   synchronous clear of overflow / dropped_count
//   mem_addr      out  framebuffer write address    [AW]
//   mem_data      out  framebuffer write colour     [3]
//   mem_we        out  framebuffer write request
//   busy          out  requests pending or a write outstanding
//   overflow      out  sticky: a request was lost to a full FIFO
//   dropped_count out  saturating count of dropped requests [8]
module pixel_write_receiver #(
  parameter int SCR_WIDTH  = 160,
  parameter int SCR_HEIGHT = 120,
  parameter int XW         = 8,
  parameter int YW         = 7,
  parameter int AW         = 15,
  parameter int DEPTH      = 4
) (
  input  logic          Clck,
  input  logic          Reset,
  input  logic [XW-1:0] paint_x_co,
  input  logic [YW-1:0] paint_y_co,
  input  logic [2:0]    color,
  input  logic          print_enable,
  input  logic          mem_ready,
  input  logic          clear_flags,
  output logic [AW-1:0] mem_addr,
  output logic [2:0]    mem_data,
  output logic          mem_we,
  output logic          busy,
  output logic          overflow,
  output logic [7:0]    dropped_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic          r_pe_prev;
  logic          r_overflow;
  logic [7:0]    r_dropped;

  logic [AW-1:0] r_fifo_addr [DEPTH];
  logic [2:0]    r_fifo_data [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic [AW-1:0] r_mem_addr;
  logic [2:0]    r_mem_data;

  logic          w_cap;
  logic          w_in_range;
  logic [AW-1:0] w_addr;
  logic          w_xfer;
  logic          w_push_ok;
  logic          w_push;
  logic          w_full_drop;
  logic          w_drop;
  logic [CW-1:0] w_count_after_pop;
  logic [CW-1:0] w_count_nx;
  logic [PW-1:0] w_rd_nx;
  logic          w_load;
  logic [AW-1:0] w_head_addr;
  logic [2:0]    w_head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------- capture
  assign w_cap      = print_enable & ~r_pe_prev;
  assign w_in_range = (32'(paint_x_co) < 32'(SCR_WIDTH)) &&
                      (32'(paint_y_co) < 32'(SCR_HEIGHT));
  assign w_addr     = AW'(32'(paint_y_co) * 32'(SCR_WIDTH) + 32'(paint_x_co));

  // The entry being offered on mem_addr/mem_data stays in the FIFO (and in
  // r_count) until its transfer cycle, so ISSUE is exactly "count != 0" and a
  // freed slot can be refilled in the very cycle it transfers.
  assign w_xfer      = (r_state == ISSUE) & mem_ready;
  assign w_push_ok   = (r_count < CW'(DEPTH)) | w_xfer;
  assign w_push      = w_cap & w_in_range & w_push_ok;
  assign w_full_drop = w_cap & w_in_range & ~w_push_ok;
  assign w_drop      = w_cap & (~w_in_range | ~w_push_ok);

  assign w_count_after_pop = r_count - CW'(w_xfer);
  assign w_count_nx        = w_count_after_pop + CW'(w_push);
  assign w_rd_nx           = w_xfer ? ptr_inc(r_rd) : r_rd;

  // ------------------------------------------------------------------- FIFO
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= w_rd_nx;
      r_count <= w_count_nx;
      if (w_push) r_wr <= ptr_inc(r_wr);
    end
  end

  always_ff @(posedge Clck) begin
    if (w_push) begin
      r_fifo_addr[r_wr] <= w_addr;
      r_fifo_data[r_wr] <= color;
    end
  end

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_push) w_state_nx = ISSUE;
      ISSUE:   if (w_xfer && (w_count_nx == '0)) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Next head: a request arriving into an otherwise empty queue is forwarded
  // straight to the output registers, giving one-cycle latency.
  always_comb begin
    w_load      = 1'b0;
    w_head_addr = r_fifo_addr[w_rd_nx];
    w_head_data = r_fifo_data[w_rd_nx];
    if (w_count_after_pop == '0) begin
      w_head_addr = w_addr;
      w_head_data = color;
    end
    case (r_state)
      IDLE:    w_load = w_push;
      ISSUE:   w_load = w_xfer & (w_count_nx != '0);
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (w_load) begin
      r_mem_addr <= w_head_addr;
      r_mem_data <= w_head_data;
    end
  end

  // ------------------------------------------------------- edge and flags
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      r_pe_prev  <= 1'b1;
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else begin
      r_pe_prev <= print_enable;
      if (clear_flags) begin
        r_overflow <= 1'b0;
        r_dropped  <= {7'd0, w_drop};
      end else begin
        if (w_full_drop) r_overflow <= 1'b1;
        if (w_drop && (r_dropped != 8'hFF)) r_dropped <= r_dropped + 8'd1;
      end
    end
  end

  assign mem_we        = (r_state == ISSUE);
  assign mem_addr      = r_mem_addr;
  assign mem_data      = r_mem_data;
  assign busy          = (r_count != '0) | mem_we;
  assign overflow      = r_overflow;
  assign dropped_count = r_dropped;

endmodule

// File: tb/tb_pixel_write_receiver.sv
module tb_pixel_write_receiver;

  logic        Clck  = 1'b0;
  logic        Reset = 1'b1;
  logic        pe    = 1'b0;
  logic        rdy   = 1'b0;
  logic        clr   = 1'b0;
  logic [7:0]  x     = '0;
  logic [6:0]  y     = '0;
  logic [2:0]  col   = '0;

  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        busy;
  logic        overflow;
  logic [7:0]  dropped_count;

  always #5 Clck = ~Clck;

  pixel_write_receiver #(
    .SCR_WIDTH (160),
    .SCR_HEIGHT(120),
    .XW        (8),
    .YW        (7),
    .AW        (15),
    .DEPTH     (4)
  ) dut (
    .Clck         (Clck),
    .Reset        (Reset),
    .paint_x_co   (x),
    .paint_y_co   (y),
    .color        (col),
    .print_enable (pe),
    .mem_ready    (rdy),
    .clear_flags  (clr),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .busy         (busy),
    .overflow     (overflow),
    .dropped_count(dropped_count)
  );

  typedef struct {
    int unsigned a;
    int unsigned d;
  } ent_t;

  // Reference model: a queue of accepted requests, head = the write on offer.
  ent_t        mq[$];
  ent_t        obs[$];
  ent_t        exp_l[$];
  bit          m_prev;
  bit          m_ovf;
  int unsigned m_drop;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_prev = 1'b1;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // One clock: check outputs at the falling edge, advance the model with the
  // inputs that the coming rising edge will sample, then move past the edge.
  task automatic step();
    bit          cap, xfer, drop, full;
    int unsigned xi, yi;
    @(negedge Clck);
    chk("mem_we",   32'(mem_we),        32'(mq.size() > 0));
    chk("busy",     32'(busy),          32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("mem_addr", 32'(mem_addr), mq[0].a);
      chk("mem_data", 32'(mem_data), mq[0].d);
    end
    chk("overflow", 32'(overflow),      32'(m_ovf));
    chk("dropped",  32'(dropped_count), m_drop);
    if (mem_we && rdy) obs.push_back('{a: 32'(mem_addr), d: 32'(mem_data)});

    xi   = 32'(x);
    yi   = 32'(y);
    cap  = pe && !m_prev;
    xfer = (mq.size() > 0) && rdy;
    drop = 1'b0;
    full = 1'b0;
    if (xfer) void'(mq.pop_front());
    if (cap) begin
      if (xi >= 160 || yi >= 120) drop = 1'b1;
      else if (mq.size() < 4) mq.push_back('{a: (yi * 160 + xi) % 32768, d: 32'(col)});
      else begin
        drop = 1'b1;
        full = 1'b1;
      end
    end
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = drop ? 1 : 0;
    end else begin
      if (full) m_ovf = 1'b1;
      if (drop && m_drop < 255) m_drop++;
    end
    m_prev = pe;
    @(posedge Clck);
    #1;
  endtask

  task automatic edge_req(input int unsigned xv, input int unsigned yv, input int unsigned cv);
    x  = 8'(xv);
    y  = 7'(yv);
    col = 3'(cv);
    pe = 1'b1;
    step();
    pe = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    32'(mem_we),        32'd0);
    chk({tag, "_busy"},  32'(busy),          32'd0);
    chk({tag, "_addr"},  32'(mem_addr),      32'd0);
    chk({tag, "_data"},  32'(mem_data),      32'd0);
    chk({tag, "_ovf"},   32'(overflow),      32'd0);
    chk({tag, "_drop"},  32'(dropped_count), 32'd0);
  endtask

  initial begin
    int unsigned xv, yv, cv;

    // Reset values
    #1 Reset = 1'b0;
    #2 check_reset_outputs("rst");
    @(posedge Clck);
    @(posedge Clck);
    #1;
    model_reset();
    Reset = 1'b1;
    step();
    step();

    // Single write, enable held 3 cycles, one-cycle latency
    rdy = 1'b1;
    obs.delete();
    x = 8'd5; y = 7'd2; col = 3'b110;
    pe = 1'b1;
    step(); step(); step();
    pe = 1'b0;
    step(); step();
    chk("s44_nwr",  32'(obs.size()), 32'd1);
    if (obs.size() > 0) begin
      chk("s44_addr", obs[0].a, 32'd325);
      chk("s44_data", obs[0].d, 32'd6);
    end

    // Out-of-range x
    obs.delete();
    edge_req(160, 0, 1);
    step();
    chk("s45_nwr",  32'(obs.size()),   32'd0);
    chk("s45_drop", 32'(dropped_count), 32'd1);
    chk("s45_ovf",  32'(overflow),      32'd0);

    // Overflow with a stalled framebuffer, then in-order drain
    clr = 1'b1; step(); clr = 1'b0;
    rdy = 1'b0;
    obs.delete();
    exp_l.delete();
    for (int i = 0; i < 6; i++) begin
      xv = $urandom_range(0, 159);
      yv = $urandom_range(0, 119);
      cv = $urandom_range(0, 7);
      if (i < 4) exp_l.push_back('{a: yv * 160 + xv, d: cv});
      edge_req(xv, yv, cv);
    end
    chk("s46_ovf",  32'(overflow),      32'd1);
    chk("s46_drop", 32'(dropped_count), 32'd2);
    rdy = 1'b1;
    repeat (6) step();
    chk("s46_nwr", 32'(obs.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      chk("s46_addr", obs[i].a, exp_l[i].a);
      chk("s46_data", obs[i].d, exp_l[i].d);
    end

    // Hold while mem_ready is low
    obs.delete();
    rdy = 1'b0;
    x = 8'd17; y = 7'd33; col = 3'd5;
    pe = 1'b1; step();
    pe = 1'b0; step(); step();
    rdy = 1'b1; step(); step();
    chk("s47_nwr", 32'(obs.size()), 32'd1);
    if (obs.size() > 0) begin
      chk("s47_addr", obs[0].a, 32'd5297);
      chk("s47_data", obs[0].d, 32'd5);
    end

    // clear_flags coinciding with a full-FIFO drop
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) edge_req($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7));
    clr = 1'b1;
    x = 8'd3; y = 7'd4; pe = 1'b1;
    step();
    clr = 1'b0; pe = 1'b0;
    step();
    chk("clr_ovf",  32'(overflow),      32'd0);
    chk("clr_drop", 32'(dropped_count), 32'd1);
    edge_req(9, 9, 1);
    chk("clr2_ovf",  32'(overflow),      32'd1);
    chk("clr2_drop", 32'(dropped_count), 32'd2);
    rdy = 1'b1;
    repeat (6) step();

    // Reset during ISSUE with requests queued, enable high through release
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) edge_req($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7));
    pe = 1'b1;
    #2 Reset = 1'b0;
    #1 check_reset_outputs("s48");
    model_reset();
    obs.delete();
    @(posedge Clck);
    @(posedge Clck);
    #1;
    rdy = 1'b1;
    Reset = 1'b1;
    repeat (5) step();
    chk("s48_nwr", 32'(obs.size()), 32'd0);
    pe = 1'b0;
    step();

    // Saturation of dropped_count, then clear
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        xv = $urandom_range(160, 255);
        yv = $urandom_range(0, 127);
      end else begin
        xv = $urandom_range(0, 255);
        yv = $urandom_range(120, 127);
      end
      edge_req(xv, yv, $urandom_range(0, 7));
    end
    chk("s49_sat", 32'(dropped_count), 32'd255);
    clr = 1'b1; step();
    clr = 1'b0; step();
    chk("s49_clr", 32'(dropped_count), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) pe = ~pe;
      if ($urandom_range(0, 6) != 0) begin
        x = 8'($urandom_range(0, 159));
        y = 7'($urandom_range(0, 119));
      end else begin
        x = 8'($urandom_range(0, 255));
        y = 7'($urandom_range(0, 127));
      end
      col = 3'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      step();
    end
    clr = 1'b0;
    pe  = 1'b0;
    rdy = 1'b1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
